reg_writeback_arbiter: RTL and testbench
========================================

// Module: reg_writeback_arbiter
// PURPOSE
//  Write-side master for the 32-entry register file: merges a single-cycle ALU result stream and a
//  long-latency LSU result stream into the single write port (we3/ad3/wd3).
//  ALU always has priority. LSU results are buffered in an in-order FIFO with valid/ready.
//  Exports a pending mask so issue logic can stall on registers with queued LSU writes.
// PARAMETERS
//  ADDRESS_WIDTH  5   register index width (2**ADDRESS_WIDTH registers)
//  DATA_WIDTH     32  result / write-data width
//  DEPTH          4   LSU FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1              clock, all state on posedge
//  rst_n      in   1              synchronous reset, active-low
//  alu_valid  in   1              ALU result present this cycle (never back-pressured)
//  alu_rd     in   ADDRESS_WIDTH  ALU destination register
//  alu_data   in   DATA_WIDTH     ALU result
//  lsu_valid  in   1              LSU result offered
//  lsu_ready  out  1              FIFO can accept; transfer when lsu_valid && lsu_ready
//  lsu_rd     in   ADDRESS_WIDTH  LSU destination register
//  lsu_data   in   DATA_WIDTH     LSU result
//  we3        out  1              register-file write enable (registered)
//  ad3        out  ADDRESS_WIDTH  register-file write address (registered)
//  wd3        out  DATA_WIDTH     register-file write data (registered)
//  pending    out  2**ADDRESS_WIDTH  bit r=1 iff a live FIFO entry targets r; bit 0 always 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): we3=0, ad3=0, wd3=0, FIFO count=0, all live bits cleared, pending=0.
//  lsu_ready = rst_n && (count < DEPTH). Combinational from registered count, so no same-cycle pop credit.
//  Writes to register 0 are never issued: alu_rd==0 is ignored; an LSU push with lsu_rd==0 is
//  accepted but stored non-live.
//  Each FIFO entry holds {live, rd, data}.
//  Per-cycle selection, computed at cycle N and registered into we3/ad3/wd3 at posedge end of N:
//   1. alu_valid && alu_rd!=0: output the ALU write.
//   2. else if count>0: pop the head. Output we3=head.live, ad3=head.rd, wd3=head.data.
//      Non-live heads pop with we3=0.
//   3. else we3=0; ad3/wd3 hold their previous values.
//  ALU write latency 1 cycle. LSU write latency >=2 cycles (push at N, earliest pop at N+1,
//  we3 at N+2), or 1 cycle with bypass.
//  Kill rule (WAW ordering): when an ALU write to r is accepted, clear live on every FIFO entry with
//  rd==r. This includes an LSU entry pushed in the same cycle with lsu_rd==r, because the ALU is
//  treated as younger.
//  pending is recomputed from the registered live/rd fields each cycle.
//  Simultaneous push and pop: both occur; count unchanged; push into the tail, pop from the head.
//  Pointers wrap modulo DEPTH. When full, lsu_ready=0 and no push occurs even if a pop happens
//  that cycle.
//  No FSM beyond the FIFO; the block is stateless apart from the FIFO and the output registers.
//  Reset mid-operation discards all queued entries; no write is issued in the reset cycle.
// CONFIGURATION
//  WB_BYPASS_EN defined: if count==0, there is no ALU write this cycle, and an LSU push occurs, the
//   pushed result goes straight to the output registers (1-cycle latency) and is not enqueued.
//   An lsu_rd==0 push bypasses with we3=0.
//  WB_BYPASS_EN undefined: every LSU result passes through the FIFO (>=2-cycle latency).
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles with alu_valid=1 -> we3=0, pending=0, lsu_ready=0.
//    After release, lsu_ready=1.
//  - ALU only: alu rd=5, data=0xDEADBEEF at N -> we3=1, ad3=5, wd3=0xDEADBEEF at N+1.
//    alu rd=0 -> we3=0.
//  - LSU fill: push rd=1..4 (data 0x11..0x44) with alu_valid=1 (rd=7) continuously.
//    -> lsu_ready=0 after the 4th push; pending=0x1E.
//    Drop alu_valid -> writes rd 1,2,3,4 in order on consecutive cycles; pending clears per pop.
//  - Kill: queue LSU rd=9 data=0xAA, then ALU rd=9 data=0xBB -> we3 writes 0xBB.
//    The later pop of rd=9 issues we3=0; pending[9] drops the cycle after the ALU write.
//  - Same-cycle collision: LSU push rd=3 and ALU rd=3 in the same cycle -> only the ALU write occurs.
//  - Bypass: with WB_BYPASS_EN, empty FIFO, LSU push rd=6 data=0x66 at N -> we3=1, ad3=6 at N+1.
//    Without WB_BYPASS_EN -> the same write appears at N+2.

Source files
------------

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, LSU results queue in an in-order FIFO.
// Define WB_BYPASS_EN to let an LSU result skip the empty FIFO straight to the write port.
module reg_writeback_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [ADDRESS_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]       lsu_data,
  output logic                        we3,
  output logic [ADDRESS_WIDTH-1:0]    ad3,
  output logic [DATA_WIDTH-1:0]       wd3,
  output logic [2**ADDRESS_WIDTH-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam int NREG = 2**ADDRESS_WIDTH;

  logic [DEPTH-1:0]         r_live;
  logic [ADDRESS_WIDTH-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [CW-1:0]            r_count;

  logic                     r_we3;
  logic [ADDRESS_WIDTH-1:0] r_ad3;
  logic [DATA_WIDTH-1:0]    r_wd3;

  logic            w_ready;
  logic            w_push;
  logic            w_alu_wr;
  logic            w_pop;
  logic            w_bypass;
  logic            w_enq;
  logic            w_push_live;
  logic [NREG-1:0] w_pending;

  assign w_ready  = rst_n && (r_count < LP_DEPTH);
  assign w_push   = lsu_valid && w_ready;
  assign w_alu_wr = alu_valid && (alu_rd != '0);
  assign w_pop    = !w_alu_wr && (r_count != '0);

`ifdef WB_BYPASS_EN
  assign w_bypass = !w_alu_wr && (r_count == '0) && w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq = w_push && !w_bypass;

  // The ALU write is younger than any LSU result, including one pushed this same cycle.
  assign w_push_live = (lsu_rd != '0) && !(w_alu_wr && (lsu_rd == alu_rd));

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_pending[r_rd[i]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alu_wr && (r_rd[i] == alu_rd)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + PW'(1);
      end
      if (w_enq) begin
        r_live[r_wptr] <= w_push_live;
        r_wptr         <= r_wptr + PW'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload carries no reset; validity is governed entirely by count and live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= lsu_rd;
      r_data[r_wptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we3 <= 1'b0;
      r_ad3 <= '0;
      r_wd3 <= '0;
    end else if (w_alu_wr) begin
      r_we3 <= 1'b1;
      r_ad3 <= alu_rd;
      r_wd3 <= alu_data;
    end else if (w_pop) begin
      r_we3 <= r_live[r_rptr];
      r_ad3 <= r_rd[r_rptr];
      r_wd3 <= r_data[r_rptr];
    end else if (w_bypass) begin
      r_we3 <= (lsu_rd != '0);
      r_ad3 <= lsu_rd;
      r_wd3 <= lsu_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign lsu_ready = w_ready;
  assign we3       = r_we3;
  assign ad3       = r_ad3;
  assign wd3       = r_wd3;
  assign pending   = w_pending;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter; expected values are hand-computed per vector.
module tb_reg_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic [31:0] pending;

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  reg_writeback_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we3(we3), .ad3(ad3), .wd3(wd3), .pending(pending)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_alu(1'b1, 5'd5, 32'h1);
    set_lsu(1'b0, 5'd0, 32'h0);
    #1;
    tick();
    tick();
    check_vec("rst_we3", we3, 0);
    check_vec("rst_ad3", ad3, 0);
    check_vec("rst_wd3", wd3, 0);
    check_vec("rst_pending", pending, 0);
    check_vec("rst_ready", lsu_ready, 0);

    rst_n = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    #1;
    check_vec("rel_ready", lsu_ready, 1);
    tick();

    // ALU only
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_vec("alu_we3", we3, 1);
    check_vec("alu_ad3", ad3, 5);
    check_vec("alu_wd3", wd3, 32'hDEADBEEF);
    set_alu(1'b1, 5'd0, 32'h1234);
    tick();
    check_vec("alu_r0_we3", we3, 0);
    check_vec("alu_r0_ad3_hold", ad3, 5);
    check_vec("alu_r0_wd3_hold", wd3, 32'hDEADBEEF);

    // LSU fill behind continuous ALU traffic, then drain in order
    set_alu(1'b1, 5'd7, 32'h77);
    for (int k = 1; k <= 4; k++) begin
      set_lsu(1'b1, 5'(k), 32'h11 * k);
      #1;
      check_vec($sformatf("fill_ready_%0d", k), lsu_ready, 1);
      tick();
      check_vec($sformatf("fill_alu_ad3_%0d", k), ad3, 7);
    end
    check_vec("full_ready", lsu_ready, 0);
    check_vec("full_pending", pending, 32'h1E);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_vec($sformatf("drain_we3_%0d", k), we3, 1);
      check_vec($sformatf("drain_ad3_%0d", k), ad3, k);
      check_vec($sformatf("drain_wd3_%0d", k), wd3, 32'h11 * k);
      check_vec($sformatf("drain_pending_%0d", k), pending, 32'h1E & ~((32'h1 << (k + 1)) - 1));
    end
    tick();
    check_vec("idle_we3", we3, 0);

    // Kill: queued rd=9 overwritten by a later ALU write to rd=9
    set_alu(1'b1, 5'd7, 32'h70);
    set_lsu(1'b1, 5'd9, 32'hAA);
    tick();
    check_vec("kill_q_pending", pending, 32'h200);
    check_vec("kill_q_ad3", ad3, 7);
    set_lsu(1'b0, 5'd0, 32'h0);
    set_alu(1'b1, 5'd9, 32'hBB);
    tick();
    check_vec("kill_alu_we3", we3, 1);
    check_vec("kill_alu_ad3", ad3, 9);
    check_vec("kill_alu_wd3", wd3, 32'hBB);
    check_vec("kill_pending", pending, 0);
    set_alu(1'b0, 5'd0, 32'h0);
    tick();
    check_vec("kill_pop_we3", we3, 0);
    check_vec("kill_pop_wd3", wd3, 32'hAA);

    // Same-cycle collision on rd=3
    set_alu(1'b1, 5'd3, 32'h33);
    set_lsu(1'b1, 5'd3, 32'h3C);
    tick();
    check_vec("coll_we3", we3, 1);
    check_vec("coll_wd3", wd3, 32'h33);
    check_vec("coll_pending", pending, 0);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    tick();
    check_vec("coll_pop_we3", we3, 0);
    check_vec("coll_pop_wd3", wd3, 32'h3C);

    // Empty FIFO, lone LSU push: latency depends on bypass
    set_lsu(1'b1, 5'd6, 32'h66);
    tick();
    set_lsu(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    check_vec("byp_n1_we3", we3, 1);
    check_vec("byp_n1_ad3", ad3, 6);
    check_vec("byp_n1_wd3", wd3, 32'h66);
    check_vec("byp_n1_pending", pending, 0);
    tick();
    check_vec("byp_n2_we3", we3, 0);
`else
    check_vec("nobyp_n1_we3", we3, 0);
    check_vec("nobyp_n1_pending", pending, 32'h40);
    tick();
    check_vec("nobyp_n2_we3", we3, 1);
    check_vec("nobyp_n2_ad3", ad3, 6);
    check_vec("nobyp_n2_wd3", wd3, 32'h66);
`endif
    tick();

    // Full FIFO with a pop in the same cycle still refuses the push; rd=0 push stored non-live
    set_alu(1'b1, 5'd7, 32'h77);
    set_lsu(1'b1, 5'd11, 32'hB1); tick();
    set_lsu(1'b1, 5'd0,  32'hB0); tick();
    set_lsu(1'b1, 5'd13, 32'hB3); tick();
    set_lsu(1'b1, 5'd14, 32'hB4); tick();
    check_vec("full2_pending", pending, (32'h1 << 11) | (32'h1 << 13) | (32'h1 << 14));
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b1, 5'd15, 32'hF0);
    #1;
    check_vec("full2_ready", lsu_ready, 0);
    tick();
    set_lsu(1'b0, 5'd0, 32'h0);
    check_vec("full2_pop_ad3", ad3, 11);
    check_vec("full2_ready_after", lsu_ready, 1);
    check_vec("full2_pending_after", pending, (32'h1 << 13) | (32'h1 << 14));
    tick();
    check_vec("r0_pop_we3", we3, 0);
    check_vec("r0_pop_wd3", wd3, 32'hB0);
    tick();
    check_vec("full2_d13", ad3, 13);
    tick();
    check_vec("full2_d14", ad3, 14);
    tick();
    check_vec("full2_no_push_we3", we3, 0);
    check_vec("full2_no_push_pending", pending, 0);

    // Reset mid-operation discards queued entries
    set_alu(1'b1, 5'd7, 32'h77);
    set_lsu(1'b1, 5'd20, 32'hC0); tick();
    set_lsu(1'b1, 5'd21, 32'hC1); tick();
    check_vec("mid_pending", pending, (32'h1 << 20) | (32'h1 << 21));
    set_lsu(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    tick();
    check_vec("mid_rst_we3", we3, 0);
    check_vec("mid_rst_pending", pending, 0);
    rst_n = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    #1;
    check_vec("mid_rel_ready", lsu_ready, 1);
    tick();
    check_vec("mid_rel_we3", we3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
